// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and helpers for the core clock request controller
package core_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } clk_ctrl_state_t;

    // Width of a down-counter that must hold the value v; never narrower than 1 bit.
    function automatic int cnt_w(input int v);
        return (v > 0) ? $clog2(v + 1) : 1;
    endfunction

endpackage

// File: rtl/core_clock_req_ctrl_if.sv
// rtl/core_clock_req_ctrl_if.sv - activity/wake inputs and gated-clock request outputs
interface core_clock_req_ctrl_if;
    logic wfi_req;
    logic int_pending;
    logic clk_force_on;
    logic rf_access;
    logic mul_start;
    logic mul_busy;
    logic g_clk_req;
    logic g_clk_rf_req;
    logic g_clk_mul_req;
    logic sleeping;
    logic wake_pulse;

    modport master (
        output wfi_req, int_pending, clk_force_on, rf_access, mul_start, mul_busy,
        input  g_clk_req, g_clk_rf_req, g_clk_mul_req, sleeping, wake_pulse
    );

    modport slave (
        input  wfi_req, int_pending, clk_force_on, rf_access, mul_start, mul_busy,
        output g_clk_req, g_clk_rf_req, g_clk_mul_req, sleeping, wake_pulse
    );
endinterface

// File: rtl/core_clock_hold_cnt.sv
// rtl/core_clock_hold_cnt.sv - idle-hold counter keeping a clock request alive after activity
module core_clock_hold_cnt
    import core_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic activity,
    input  logic clr,
    output logic active
);
    localparam int W = cnt_w(HOLD);
    localparam logic [W-1:0] HOLD_V = W'(HOLD);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // clr wins so that activity seen while asleep never re-arms the hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (activity) begin
            cnt_d = HOLD_V;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active = (cnt_q != '0);
endmodule

// File: rtl/core_clock_req_ctrl.sv
// rtl/core_clock_req_ctrl.sv - WFI sleep/wake sequencer and gated-clock request generation
module core_clock_req_ctrl
    import core_pkg::*;
#(
    parameter int CLK_GATE_EN   = 1,
    parameter int RF_IDLE_HOLD  = 4,
    parameter int MUL_IDLE_HOLD = 8,
    parameter int DRAIN_CYCLES  = 2,
    parameter int WAKE_CYCLES   = 2
) (
    input  logic                  f_clk,
    input  logic                  g_resetn,
    core_clock_req_ctrl_if.slave  bus
);
    generate
        if (CLK_GATE_EN != 0) begin : g_gate
            localparam int WAKE_LD = (WAKE_CYCLES < 1) ? 1 : WAKE_CYCLES;
            localparam int DW      = cnt_w(DRAIN_CYCLES);
            localparam int WW      = cnt_w(WAKE_LD);
            localparam logic [DW-1:0] DRAIN_V = DW'(DRAIN_CYCLES);
            localparam logic [WW-1:0] WAKE_V  = WW'(WAKE_LD);

            clk_ctrl_state_t state_d, state_q;
            logic [DW-1:0]   drain_cnt_d, drain_cnt_q;
            logic [WW-1:0]   wake_cnt_d, wake_cnt_q;
            logic            wake_pulse_d, wake_pulse_q;
            logic            rf_active, mul_active;
            logic            in_sleep;
            logic            wake_src;

            assign in_sleep = (state_q == SLEEP);
            assign wake_src = bus.int_pending | bus.clk_force_on;

            core_clock_hold_cnt #(.HOLD(RF_IDLE_HOLD)) u_rf_hold (
                .clk      (f_clk),
                .rst_n    (g_resetn),
                .activity (bus.rf_access),
                .clr      (in_sleep),
                .active   (rf_active)
            );

            core_clock_hold_cnt #(.HOLD(MUL_IDLE_HOLD)) u_mul_hold (
                .clk      (f_clk),
                .rst_n    (g_resetn),
                .activity (bus.mul_start | bus.mul_busy),
                .clr      (in_sleep),
                .active   (mul_active)
            );

            // Drain/wake counters hold the cycles remaining including the current one,
            // so a load of N spends exactly N cycles in the state.
            always_comb begin
                state_d      = state_q;
                drain_cnt_d  = drain_cnt_q;
                wake_cnt_d   = wake_cnt_q;
                wake_pulse_d = 1'b0;
                case (state_q)
                    RUN: begin
                        if (bus.wfi_req & ~wake_src & ~bus.mul_busy & ~bus.mul_start) begin
                            state_d     = DRAIN;
                            drain_cnt_d = DRAIN_V;
                        end
                    end
                    DRAIN: begin
                        if (wake_src | ~bus.wfi_req) begin
                            state_d = RUN;
                        end else if ((drain_cnt_q <= DW'(1)) & ~rf_active & ~mul_active
                                     & ~bus.mul_busy & ~bus.rf_access) begin
                            state_d     = SLEEP;
                            drain_cnt_d = '0;
                        end else if (drain_cnt_q != '0) begin
                            drain_cnt_d = drain_cnt_q - DW'(1);
                        end
                    end
                    SLEEP: begin
                        if (wake_src) begin
                            state_d    = WAKE;
                            wake_cnt_d = WAKE_V;
                        end
                    end
                    WAKE: begin
                        if (wake_cnt_q <= WW'(1)) begin
                            state_d      = RUN;
                            wake_cnt_d   = '0;
                            wake_pulse_d = 1'b1;
                        end else begin
                            wake_cnt_d = wake_cnt_q - WW'(1);
                        end
                    end
                    default: state_d = RUN;
                endcase
            end

            always_ff @(posedge f_clk or negedge g_resetn) begin
                if (!g_resetn) begin
                    state_q      <= RUN;
                    drain_cnt_q  <= '0;
                    wake_cnt_q   <= '0;
                    wake_pulse_q <= 1'b0;
                end else begin
                    state_q      <= state_d;
                    drain_cnt_q  <= drain_cnt_d;
                    wake_cnt_q   <= wake_cnt_d;
                    wake_pulse_q <= wake_pulse_d;
                end
            end

            assign bus.g_clk_req     = ~in_sleep | bus.clk_force_on;
            assign bus.g_clk_rf_req  = bus.clk_force_on | (~in_sleep & (bus.rf_access | rf_active));
            assign bus.g_clk_mul_req = bus.clk_force_on |
                                       (~in_sleep & (bus.mul_start | bus.mul_busy | mul_active));
            assign bus.sleeping      = in_sleep;
            assign bus.wake_pulse    = wake_pulse_q;
        end else begin : g_no_gate
            assign bus.g_clk_req     = 1'b1;
            assign bus.g_clk_rf_req  = 1'b1;
            assign bus.g_clk_mul_req = 1'b1;
            assign bus.sleeping      = 1'b0;
            assign bus.wake_pulse    = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_core_clock_req_ctrl.sv
// tb/tb_core_clock_req_ctrl.sv - directed self-checking bench for core_clock_req_ctrl
module tb_core_clock_req_ctrl;
    logic f_clk;
    logic g_resetn;
    int   total;
    int   bad;

    core_clock_req_ctrl_if bus();

    core_clock_req_ctrl #(
        .CLK_GATE_EN   (1),
        .RF_IDLE_HOLD  (4),
        .MUL_IDLE_HOLD (8),
        .DRAIN_CYCLES  (2),
        .WAKE_CYCLES   (2)
    ) dut (
        .f_clk    (f_clk),
        .g_resetn (g_resetn),
        .bus      (bus)
    );

    initial f_clk = 1'b0;
    always #5 f_clk = ~f_clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed away from the edge.
    task automatic cyc();
        @(posedge f_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wfi_req      = 1'b0;
        bus.int_pending  = 1'b0;
        bus.clk_force_on = 1'b0;
        bus.rf_access    = 1'b0;
        bus.mul_start    = 1'b0;
        bus.mul_busy     = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        g_resetn = 1'b0;
        repeat (3) cyc();
        g_resetn = 1'b1;
        cyc();

        // 1: reset state
        chk("rst_clk_req", bus.g_clk_req, 1'b1);
        chk("rst_rf_req", bus.g_clk_rf_req, 1'b0);
        chk("rst_mul_req", bus.g_clk_mul_req, 1'b0);
        chk("rst_sleeping", bus.sleeping, 1'b0);
        chk("rst_wake_pulse", bus.wake_pulse, 1'b0);

        // 2: RF hold, access cycle plus 4 hold cycles
        bus.rf_access = 1'b1;
        #1;
        chk("rf_access_cycle", bus.g_clk_rf_req, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            bus.rf_access = 1'b0;
            #1;
            chk($sformatf("rf_hold_%0d", i), bus.g_clk_rf_req, 1'b1);
        end
        cyc();
        chk("rf_hold_end", bus.g_clk_rf_req, 1'b0);

        // 3: sleep entry after 2 DRAIN cycles, then wake
        bus.wfi_req = 1'b1;
        #1;
        chk("wfi_run_clk_req", bus.g_clk_req, 1'b1);
        cyc();
        chk("drain1_sleeping", bus.sleeping, 1'b0);
        chk("drain1_clk_req", bus.g_clk_req, 1'b1);
        cyc();
        chk("drain2_sleeping", bus.sleeping, 1'b0);
        cyc();
        chk("sleep_sleeping", bus.sleeping, 1'b1);
        chk("sleep_clk_req", bus.g_clk_req, 1'b0);
        bus.int_pending = 1'b1;
        #1;
        chk("sleep_int_clk_req", bus.g_clk_req, 1'b0);
        cyc();
        bus.int_pending = 1'b0;
        bus.wfi_req     = 1'b0;
        #1;
        chk("wake1_sleeping", bus.sleeping, 1'b0);
        chk("wake1_clk_req", bus.g_clk_req, 1'b1);
        chk("wake1_pulse", bus.wake_pulse, 1'b0);
        cyc();
        chk("wake2_pulse", bus.wake_pulse, 1'b0);
        cyc();
        chk("run1_pulse", bus.wake_pulse, 1'b1);
        cyc();
        chk("run2_pulse", bus.wake_pulse, 1'b0);

        // 4: int_pending in the last DRAIN cycle aborts sleep
        bus.wfi_req = 1'b1;
        cyc();
        chk("abort_drain1_clk", bus.g_clk_req, 1'b1);
        cyc();
        chk("abort_drain2_clk", bus.g_clk_req, 1'b1);
        bus.int_pending = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("abort_clk_%0d", i), bus.g_clk_req, 1'b1);
            chk($sformatf("abort_sleep_%0d", i), bus.sleeping, 1'b0);
        end
        idle_inputs();
        cyc();

        // 5: mul_busy blocks drain, then 8 hold cycles before sleep
        bus.wfi_req  = 1'b1;
        bus.mul_busy = 1'b1;
        #1;
        chk("mul_busy_req", bus.g_clk_mul_req, 1'b1);
        repeat (3) cyc();
        bus.mul_busy = 1'b0;
        #1;
        chk("mul_hold_1", bus.g_clk_mul_req, 1'b1);
        chk("mul_busy_no_sleep", bus.sleeping, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            cyc();
            chk($sformatf("mul_hold_%0d", i), bus.g_clk_mul_req, 1'b1);
            chk($sformatf("mul_wait_sleep_%0d", i), bus.sleeping, 1'b0);
        end
        cyc();
        chk("mul_hold_end", bus.g_clk_mul_req, 1'b0);
        chk("mul_last_drain", bus.sleeping, 1'b0);
        cyc();
        chk("mul_sleep", bus.sleeping, 1'b1);
        chk("mul_sleep_clk", bus.g_clk_req, 1'b0);

        // 6: activity ignored in SLEEP, force pulse, async reset in SLEEP
        bus.rf_access = 1'b1;
        bus.mul_start = 1'b1;
        #1;
        chk("sleep_rf_ignored", bus.g_clk_rf_req, 1'b0);
        chk("sleep_mul_ignored", bus.g_clk_mul_req, 1'b0);
        bus.clk_force_on = 1'b1;
        #1;
        chk("force_clk", bus.g_clk_req, 1'b1);
        chk("force_rf", bus.g_clk_rf_req, 1'b1);
        chk("force_mul", bus.g_clk_mul_req, 1'b1);
        bus.clk_force_on = 1'b0;
        bus.rf_access    = 1'b0;
        bus.mul_start    = 1'b0;
        #1;
        chk("force_off_clk", bus.g_clk_req, 1'b0);
        cyc();
        chk("still_sleep", bus.sleeping, 1'b1);
        chk("sleep_rf_not_armed", bus.g_clk_rf_req, 1'b0);
        #1;
        g_resetn = 1'b0;
        #1;
        chk("async_rst_clk", bus.g_clk_req, 1'b1);
        chk("async_rst_sleep", bus.sleeping, 1'b0);
        bus.wfi_req = 1'b0;
        cyc();
        g_resetn = 1'b1;
        cyc();

        // wfi_req together with int_pending in RUN never leaves RUN
        bus.wfi_req     = 1'b1;
        bus.int_pending = 1'b1;
        repeat (5) cyc();
        chk("wfi_int_run_clk", bus.g_clk_req, 1'b1);
        bus.int_pending = 1'b0;
        repeat (4) cyc();
        chk("wfi_after_int_sleep", bus.sleeping, 1'b1);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
